// File: rtl/fifo_stream_writer.sv
// Streams a LEN-word burst from a valid/ready source into the operand FIFO, tracking a mirror
// occupancy count so the flag-less FIFO never exceeds DEPTH-1. Option: STREAM_WRITER_OCC_EN.
module fifo_stream_writer #(
   parameter int DATA_BITWIDTH = 8,
   parameter int ADDR_BITWIDTH = 4,
   parameter int LEN_BITWIDTH  = 8
) (
   input  logic                     clk,
   input  logic                     rstN,
   input  logic                     start,
   input  logic [LEN_BITWIDTH-1:0]  len,
   output logic                     busy,
   output logic                     done,
   input  logic                     s_valid,
   input  logic [DATA_BITWIDTH-1:0] s_data,
   output logic                     s_ready,
   input  logic                     fifo_re,
   output logic                     fifo_we,
   output logic [DATA_BITWIDTH-1:0] fifo_din,
`ifdef STREAM_WRITER_OCC_EN
   output logic [ADDR_BITWIDTH-1:0] occ_out,
   output logic                     almost_full,
`endif
   output logic [1:0]               state_dbg
);

   // Handshake: a word moves when s_valid && s_ready at a rising edge; s_ready never
   // depends on s_valid, and the source must hold s_data while s_valid is high and not accepted.

   localparam int DEPTH = 1 << ADDR_BITWIDTH;
   localparam logic [ADDR_BITWIDTH:0]   FULL_LIM = (ADDR_BITWIDTH+1)'(DEPTH - 1);
   localparam logic [LEN_BITWIDTH-1:0]  REM_ONE  = LEN_BITWIDTH'(1);
   localparam logic [ADDR_BITWIDTH-1:0] OCC_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   state_t                     state_q, state_d;
   logic [LEN_BITWIDTH-1:0]    rem_q, rem_d;
   logic [ADDR_BITWIDTH-1:0]   occ_q, occ_d;
   logic                       we_q, we_d;
   logic [DATA_BITWIDTH-1:0]   din_q, din_d;
   logic                       done_q, done_d;

   logic [ADDR_BITWIDTH:0]     occ_inflight;
   logic [ADDR_BITWIDTH-1:0]   we_ext;
   logic [ADDR_BITWIDTH-1:0]   pop_ext;
   logic                       ready_c;
   logic                       accept;
   logic                       pop;

   always_comb begin
      // Conservative limit: counts the write already in flight, ignores a same-cycle pop.
      occ_inflight = {1'b0, occ_q} + {{ADDR_BITWIDTH{1'b0}}, we_q};
      ready_c      = (state_q == LOAD) && (rem_q != '0) && (occ_inflight < FULL_LIM);
      accept       = s_valid && ready_c;
      pop          = fifo_re && (occ_q != OCC_ZERO);
      we_ext       = {{(ADDR_BITWIDTH-1){1'b0}}, we_q};
      pop_ext      = {{(ADDR_BITWIDTH-1){1'b0}}, pop};
      occ_d        = occ_q + we_ext - pop_ext;

      state_d = state_q;
      rem_d   = rem_q;
      we_d    = 1'b0;
      din_d   = din_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               rem_d   = len;
               state_d = (len == '0) ? FLUSH : LOAD;
            end
         end
         LOAD: begin
            if (accept) begin
               we_d  = 1'b1;
               din_d = s_data;
               rem_d = rem_q - REM_ONE;
               if (rem_q == REM_ONE) state_d = FLUSH;
            end
         end
         FLUSH: begin
            // The last write is on the FIFO input during this cycle; done follows it.
            state_d = IDLE;
            done_d  = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q <= IDLE;
         rem_q   <= '0;
         occ_q   <= '0;
         we_q    <= 1'b0;
         din_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         occ_q   <= occ_d;
         we_q    <= we_d;
         din_q   <= din_d;
         done_q  <= done_d;
      end
   end

   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign s_ready   = ready_c;
   assign fifo_we   = we_q;
   assign fifo_din  = din_q;
   assign state_dbg = state_q;

`ifdef STREAM_WRITER_OCC_EN
   localparam logic [ADDR_BITWIDTH-1:0] AF_LIM = ADDR_BITWIDTH'(DEPTH - 2);
   assign occ_out     = occ_q;
   assign almost_full = (occ_q >= AF_LIM);
`endif

endmodule

// File: tb/tb_fifo_stream_writer.sv
// Bench for fifo_stream_writer: queue/integer model checked every cycle on the falling edge,
// plus directed scenarios with literal expectations.
module tb_fifo_stream_writer;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int LW    = 8;
   localparam int DEPTH = 1 << AW;

   logic          clk = 1'b0;
   logic          rstN;
   logic          start;
   logic [LW-1:0] len;
   logic          busy;
   logic          done;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          fifo_re;
   logic          fifo_we;
   logic [DW-1:0] fifo_din;
   logic [1:0]    state_dbg;
`ifdef STREAM_WRITER_OCC_EN
   logic [AW-1:0] occ_out;
   logic          almost_full;
`endif

   fifo_stream_writer #(.DATA_BITWIDTH(DW), .ADDR_BITWIDTH(AW), .LEN_BITWIDTH(LW)) dut (
      .clk(clk), .rstN(rstN), .start(start), .len(len), .busy(busy), .done(done),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .fifo_re(fifo_re),
      .fifo_we(fifo_we), .fifo_din(fifo_din),
`ifdef STREAM_WRITER_OCC_EN
      .occ_out(occ_out), .almost_full(almost_full),
`endif
      .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- model + scoreboard ----------------
   logic [DW-1:0] exp_q[$];
   int m_phase = 0;   // 0 idle, 1 loading, 2 flushing
   int m_rem   = 0;
   int m_occ   = 0;
   int m_we    = 0;
   int m_din   = 0;
   int m_done  = 0;
   int cyc = 0, we_cnt = 0, done_cnt = 0;
   int first_we_cyc = -1, last_we_cyc = 0, done_cyc = 0;

   always @(negedge clk) begin
      int m_ready, pop, n_occ, n_we, n_done;
      logic [DW-1:0] w;
      cyc++;
      if (!rstN) begin
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_we", fifo_we, 0);
         chk("rst_din", fifo_din, 0);
         chk("rst_ready", s_ready, 0);
         m_phase = 0; m_rem = 0; m_occ = 0; m_we = 0; m_din = 0; m_done = 0;
         exp_q.delete();
      end else begin
         m_ready = (m_phase == 1 && m_rem > 0 && (m_occ + m_we) < DEPTH - 1) ? 1 : 0;
         chk("busy", busy, (m_phase != 0) ? 1 : 0);
         chk("done", done, m_done);
         chk("s_ready", s_ready, m_ready);
         chk("fifo_we", fifo_we, m_we);
         chk("fifo_din", fifo_din, m_din);
`ifdef STREAM_WRITER_OCC_EN
         chk("occ_out", occ_out, m_occ);
         chk("almost_full", almost_full, (m_occ >= DEPTH - 2) ? 1 : 0);
`endif
         if (fifo_we) begin
            we_cnt++;
            last_we_cyc = cyc;
            if (first_we_cyc < 0) first_we_cyc = cyc;
            if (exp_q.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               w = exp_q.pop_front();
               chk("sb_data", fifo_din, w);
            end
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         // advance the model across the coming rising edge
         pop   = (fifo_re && m_occ > 0) ? 1 : 0;
         n_occ = m_occ + m_we - pop;
         if (n_occ > DEPTH - 1) chk("occ_bound", n_occ, DEPTH - 1);
         n_we = 0; n_done = 0;
         case (m_phase)
            0: if (start) begin
               m_rem   = len;
               m_phase = (len == 0) ? 2 : 1;
            end
            1: if (s_valid && m_ready != 0) begin
               n_we  = 1;
               m_din = s_data;
               exp_q.push_back(s_data);
               m_rem--;
               if (m_rem == 0) m_phase = 2;
            end
            default: begin
               m_phase = 0;
               n_done  = 1;
            end
         endcase
         m_occ = n_occ; m_we = n_we; m_done = n_done;
      end
   end

   // ---------------- driver tasks ----------------
   int            src_idx = 0;
   logic [DW-1:0] src_base = '0;

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_start(input int l);
      start = 1'b1;
      len   = LW'(l);
      step();
      start = 1'b0;
   endtask

   // Source with held data; optionally turns fifo_re on at cycle re_on; returns on done or acc_stop.
   task automatic stream(input int max_cyc, input int stop_on_done, input int acc_stop,
                         input int re_on);
      int rdy, dn, seen;
      seen = 0;
      s_data = src_base + DW'(src_idx);
      for (int c = 0; c < max_cyc; c++) begin
         if (c == re_on) fifo_re = 1'b1;
         @(negedge clk);
         rdy = s_ready;
         dn  = done;
         step();
         if (rdy != 0 && s_valid) begin
            src_idx++;
            s_data = src_base + DW'(src_idx);
         end
         if (stop_on_done != 0 && dn != 0) begin seen = 1; break; end
         if (src_idx == acc_stop) break;
      end
      if (stop_on_done != 0 && seen == 0) chk("timeout_done", 0, 1);
   endtask

   task automatic drain();
      fifo_re = 1'b1;
      repeat (DEPTH + 2) step();
      fifo_re = 1'b0;
      chk("drained_occ", dut.occ_q, 0);
   endtask

   // ---------------- directed scenarios ----------------
   initial begin
      int w0, d0;
      rstN = 1'b0; start = 1'b0; len = '0; s_valid = 1'b0; s_data = '0; fifo_re = 1'b0;
      repeat (2) step();
      chk("reset_busy", busy, 0);
      chk("reset_we", fifo_we, 0);
      chk("reset_occ", dut.occ_q, 0);
      rstN = 1'b1;
      step();

      // len=4, no reads: 4 consecutive writes, done one cycle after the last one, occ=4
      src_base = 8'hA0; src_idx = 0; s_valid = 1'b1;
      w0 = we_cnt; d0 = done_cnt; first_we_cyc = -1;
      do_start(4);
      stream(40, 1, -1, -1);
      chk("t1_writes", we_cnt - w0, 4);
      chk("t1_consec", last_we_cyc - first_we_cyc, 3);
      chk("t1_done_lat", done_cyc - last_we_cyc, 1);
      chk("t1_done_cnt", done_cnt - d0, 1);
      chk("t1_last_din", fifo_din, 8'hA3);
      chk("t1_occ", dut.occ_q, 4);
      drain();

      // len=20 into an empty FIFO with no reads: stall at 15 words, then resume on reads
      src_base = 8'h10; src_idx = 0; w0 = we_cnt; d0 = done_cnt;
      do_start(20);
      stream(30, 0, -1, -1);
      chk("t2_accepts", src_idx, 15);
      chk("t2_occ_full", dut.occ_q, 15);
      chk("t2_busy", busy, 1);
      chk("t2_ready_low", s_ready, 0);
      stream(80, 1, -1, 0);
      chk("t2_writes", we_cnt - w0, 20);
      chk("t2_done_cnt", done_cnt - d0, 1);
      drain();

      // sustained reads during len=10: every write is popped
      src_base = 8'h50; src_idx = 0; w0 = we_cnt; d0 = done_cnt;
      fifo_re = 1'b1;
      do_start(10);
      stream(40, 1, -1, -1);
      chk("t3_writes", we_cnt - w0, 10);
      chk("t3_done_cnt", done_cnt - d0, 1);
      step(); step();
      chk("t3_final_occ", dut.occ_q, 0);
      fifo_re = 1'b0;

      // len=0: busy for one cycle, done two cycles after start, no write
      w0 = we_cnt;
      do_start(0);
      chk("t4_busy", busy, 1);
      chk("t4_no_done", done, 0);
      step();
      chk("t4_done", done, 1);
      chk("t4_idle", busy, 0);
      chk("t4_no_we", we_cnt - w0, 0);
      step();

      // reset with rem=3 aborts without done; then a normal len=2 burst
      src_base = 8'h70; src_idx = 0; d0 = done_cnt;
      do_start(5);
      stream(20, 0, 2, -1);
      rstN = 1'b0;
      #1;
      chk("t5_rst_busy", busy, 0);
      chk("t5_rst_we", fifo_we, 0);
      chk("t5_rst_din", fifo_din, 0);
      s_valid = 1'b0;
      repeat (3) step();
      chk("t5_no_done", done_cnt - d0, 0);
      rstN = 1'b1;
      step();
      src_base = 8'hC0; src_idx = 0; s_valid = 1'b1; w0 = we_cnt;
      do_start(2);
      stream(20, 1, -1, -1);
      chk("t5_writes", we_cnt - w0, 2);
      chk("t5_done_cnt", done_cnt - d0, 1);
      drain();

      // start while busy is ignored; reads while empty keep occ at 0
      src_base = 8'hE0; src_idx = 0; s_valid = 1'b0; w0 = we_cnt; d0 = done_cnt;
      do_start(3);
      do_start(7);
      chk("t6_busy", busy, 1);
      s_valid = 1'b1;
      stream(30, 1, -1, -1);
      chk("t6_writes", we_cnt - w0, 3);
      chk("t6_done_cnt", done_cnt - d0, 1);
      drain();
      fifo_re = 1'b1;
      repeat (3) step();
      chk("t6_empty_re", dut.occ_q, 0);
      fifo_re = 1'b0;
      chk("sb_empty", exp_q.size(), 0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
